uart_tx_arbiter: RTL and testbench

- Shares one UART_TX byte transmitter between N_REQ packet sources.
- Grants one source at a time, round-robin, at packet boundaries.
- Frames each packet as: header byte, payload bytes, XOR checksum byte. The header byte carries the source ID.
- Drives the transmitter's WR/WDATA pulse interface and paces itself from the transmitter's IDLE flag.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {ARB, HDR, PAY, CSUM, DRAIN} state_t;

  localparam logic [3:0] HDR_TAG_DEF     = 4'hA;
  localparam int         UART_FRAME_BITS = 10;
  localparam int         ID_W            = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes plus the UART_TX write/idle handshake, bundled for the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   REQ_VALID;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]   REQ_LAST;
  logic [N_REQ-1:0]   REQ_READY;
  logic [N_REQ-1:0]   GRANT;
  logic               TX_WR;
  logic [7:0]         TX_WDATA;
  logic               TX_IDLE;
  logic               BUSY;
  logic               ABORT;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, TX_IDLE,
    input  REQ_READY, GRANT, TX_WR, TX_WDATA, BUSY, ABORT
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, TX_IDLE,
    output REQ_READY, GRANT, TX_WR, TX_WDATA, BUSY, ABORT
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id
);

  logic [ID_W:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (en && !found && req[j] && idx == (ID_W+1)'(j)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          id     = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between N_REQ packet sources; frames header, payload, XOR checksum.
//   state | meaning
//   ARB   | waiting for any requester, round-robin pick
//   HDR   | send header {HDR_TAG, id}
//   PAY   | forward payload bytes from the granted lane, stall timer running
//   CSUM  | send checksum (inverted when aborting)
//   DRAIN | wait for the last frame to leave the line
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         N_REQ         = 4,
  parameter logic [3:0] HDR_TAG       = HDR_TAG_DEF,
  parameter int         STALL_TIMEOUT = 1024
) (
  input logic              CLOCK_50M,
  input logic              RESET,
  uart_tx_arbiter_if.slave bus
);

  localparam int STALL_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_TIMEOUT - 1);

  state_t             state;
  logic [ID_W-1:0]    ptr, id, arb_id;
  logic [N_REQ-1:0]   grant, arb_gnt;
  logic [7:0]         csum, tx_wdata, sel_data;
  logic               tx_wr, tx_wr_d, busy, abort, abort_flag;
  logic               tx_free, sel_valid, sel_last, accept;
  logic [STALL_W-1:0] stall_cnt;

  // The transmitter drops IDLE only a cycle after it samples WR, so mask it for two cycles.
  assign tx_free = bus.TX_IDLE & ~tx_wr & ~tx_wr_d;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        sel_valid = bus.REQ_VALID[j];
        sel_last  = bus.REQ_LAST[j];
        sel_data  = bus.REQ_DATA[8*j +: 8];
      end
    end
  end

  assign accept        = tx_free && (state == PAY) && sel_valid;
  assign bus.REQ_READY = (tx_free && state == PAY) ? grant : '0;
  assign bus.GRANT     = grant;
  assign bus.TX_WR     = tx_wr;
  assign bus.TX_WDATA  = tx_wdata;
  assign bus.BUSY      = busy;
  assign bus.ABORT     = abort;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (bus.REQ_VALID),
    .ptr (ptr),
    .en  (state == ARB),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  always_ff @(posedge CLOCK_50M or posedge RESET) begin
    if (RESET) begin
      state      <= ARB;
      ptr        <= '0;
      id         <= '0;
      grant      <= '0;
      csum       <= '0;
      tx_wr      <= 1'b0;
      tx_wr_d    <= 1'b0;
      tx_wdata   <= '0;
      busy       <= 1'b0;
      abort      <= 1'b0;
      abort_flag <= 1'b0;
      stall_cnt  <= STALL_LOAD;
    end else begin
      tx_wr   <= 1'b0;
      abort   <= 1'b0;
      tx_wr_d <= tx_wr;
      case (state)
        ARB: begin
          if (|arb_gnt) begin
            grant      <= arb_gnt;
            id         <= arb_id;
            busy       <= 1'b1;
            csum       <= '0;
            abort_flag <= 1'b0;
            stall_cnt  <= STALL_LOAD;
            ptr        <= (arb_id == ID_W'(N_REQ-1)) ? '0 : arb_id + ID_W'(1);
            state      <= HDR;
          end
        end
        HDR: begin
          if (tx_free) begin
            tx_wr    <= 1'b1;
            tx_wdata <= {HDR_TAG, id};
            state    <= PAY;
          end
        end
        PAY: begin
          if (accept) begin
            tx_wr     <= 1'b1;
            tx_wdata  <= sel_data;
            csum      <= csum ^ sel_data;
            stall_cnt <= STALL_LOAD;
            if (sel_last) state <= CSUM;
          end else if (tx_free) begin
            if (stall_cnt == '0) begin
              abort_flag <= 1'b1;
              state      <= CSUM;
            end else begin
              stall_cnt <= stall_cnt - 1'b1;
            end
          end
        end
        CSUM: begin
          if (tx_free) begin
            tx_wr    <= 1'b1;
            tx_wdata <= abort_flag ? ~csum : csum;
            abort    <= abort_flag;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (tx_free) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART_TX (4 clocks per bit).
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N     = 4;
  localparam int T_BIT = 4;
  localparam int FRAME = UART_FRAME_BITS * T_BIT;
  localparam int STALL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus();

  uart_tx_arbiter #(.N_REQ(N), .HDR_TAG(4'hA), .STALL_TIMEOUT(STALL)) dut (
    .CLOCK_50M (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  // Transmitter model: samples WR when idle, then stays busy for one frame.
  logic tx_active;
  int   tx_cnt;
  logic force_idle = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_active <= 1'b0;
      tx_cnt    <= 0;
    end else if (!tx_active) begin
      if (bus.TX_WR) begin
        tx_active <= 1'b1;
        tx_cnt    <= FRAME - 1;
      end
    end else if (tx_cnt == 0) begin
      tx_active <= 1'b0;
    end else begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  assign bus.TX_IDLE = force_idle | ~tx_active;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  bit         have_prev = 0;
  int         min_gap = FRAME;
  int         abort_cnt = 0;
  int         wr_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && bus.TX_WR) begin
      wr_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL tx_byte: got %02h, expected no write", bus.TX_WDATA);
      end else begin
        exp_b = sb.pop_front();
        if (bus.TX_WDATA !== exp_b)
          $display("FAIL tx_byte: got %02h, expected %02h", bus.TX_WDATA, exp_b);
        else
          n_pass++;
      end
      if (have_prev) begin
        n_checks++;
        if (cyc - last_wr_cyc < min_gap)
          $display("FAIL tx_gap: got %0d cycles, expected >= %0d", cyc - last_wr_cyc, min_gap);
        else
          n_pass++;
      end
      have_prev   = 1;
      last_wr_cyc = cyc;
    end
    if (!rst && bus.ABORT) begin
      abort_cnt++;
      n_checks++;
      if (bus.TX_WR !== 1'b1)
        $display("FAIL abort_with_wr: TX_WR=%b, expected 1", bus.TX_WR);
      else
        n_pass++;
    end
  end

  function automatic void push_pkt(int s, logic [7:0] d[$]);
    logic [7:0] c = 8'h00;
    sb.push_back({4'hA, 4'(s)});
    foreach (d[i]) begin
      sb.push_back(d[i]);
      c ^= d[i];
    end
    sb.push_back(c);
  endfunction

  task automatic send_byte(int s, logic [7:0] b, logic last);
    bit ok = 0;
    bus.REQ_VALID[s]       = 1'b1;
    bus.REQ_DATA[8*s +: 8] = b;
    bus.REQ_LAST[s]        = last;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (bus.REQ_READY[s]) ok = 1;
      @(negedge clk);
    end
    bus.REQ_VALID[s] = 1'b0;
    bus.REQ_LAST[s]  = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL send_byte: src %0d byte %02h got no READY, expected READY", s, b);
    else n_pass++;
  endtask

  task automatic send_pkt(int s, logic [7:0] d[$]);
    foreach (d[i]) send_byte(s, d[i], (i == d.size() - 1));
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!bus.BUSY && sb.size() == 0) break;
    end
    n_checks++;
    if (bus.BUSY !== 1'b0 || sb.size() != 0)
      $display("FAIL %s_idle: got BUSY=%b pending=%0d, expected BUSY=0 pending=0", name, bus.BUSY, sb.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;
    bus.REQ_LAST  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.TX_WR, bus.TX_WDATA, bus.BUSY, bus.ABORT} !== 11'h0)
      $display("FAIL reset_tx: got wr=%b wdata=%02h busy=%b abort=%b, expected all 0",
               bus.TX_WR, bus.TX_WDATA, bus.BUSY, bus.ABORT);
    else n_pass++;
    n_checks++;
    if ({bus.REQ_READY, bus.GRANT} !== '0)
      $display("FAIL reset_lanes: got ready=%b grant=%b, expected 0", bus.REQ_READY, bus.GRANT);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr();
    logic [7:0] qa[$], qb[$], qc[$];
    qa = '{8'h11, 8'h22};
    qb = '{8'h80, 8'h01, 8'h02};
    qc = '{8'h5C};
    push_pkt(0, qa);
    push_pkt(2, qc);
    push_pkt(0, qb);
    fork
      begin send_pkt(0, qa); send_pkt(0, qb); end
      begin send_pkt(2, qc); end
    join
    wait_idle("rr");
  endtask

  task automatic test_single();
    logic [7:0] q[$];
    int fall = -1;
    q = '{8'h41, 8'h42};
    push_pkt(1, q);
    send_pkt(1, q);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.BUSY) begin fall = cyc; break; end
    end
    n_checks++;
    if (fall < 0 || fall - last_wr_cyc != FRAME + 2)
      $display("FAIL busy_release: got %0d cycles after last WR, expected %0d", fall - last_wr_cyc, FRAME + 2);
    else n_pass++;
    wait_idle("single");
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    int a0;
    bit got;
    a0 = abort_cnt;
    sb.push_back(8'hA3); sb.push_back(8'h10); sb.push_back(8'hEF);
    send_byte(3, 8'h10, 1'b0);
    wait_idle("stall");
    n_checks++;
    if (abort_cnt - a0 != 1) $display("FAIL stall_abort_count: got %0d, expected 1", abort_cnt - a0);
    else n_pass++;

    q = '{8'h55};
    push_pkt(1, q);
    send_pkt(1, q);
    wait_idle("after_abort");

    a0 = abort_cnt;
    got = 0;
    sb.push_back(8'hA2); sb.push_back(8'hFF);
    bus.REQ_VALID[2]     = 1'b1;
    bus.REQ_DATA[23:16]  = 8'h77;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (bus.GRANT[2]) got = 1;
    end
    bus.REQ_VALID[2] = 1'b0;
    n_checks++;
    if (!got) $display("FAIL withdraw_grant: got GRANT=%b, expected bit 2 set", bus.GRANT);
    else n_pass++;
    wait_idle("withdraw");
    n_checks++;
    if (abort_cnt - a0 != 1) $display("FAIL withdraw_abort_count: got %0d, expected 1", abort_cnt - a0);
    else n_pass++;
  endtask

  task automatic test_nongrant();
    logic [7:0] q[$];
    bit stop = 0;
    int bad = 0;
    q = '{8'h21, 8'h22, 8'h23};
    push_pkt(0, q);
    fork
      begin send_pkt(0, q); stop = 1; end
      begin
        for (int i = 0; i < 500 && !bus.GRANT[0]; i++) @(negedge clk);
        while (!stop) begin
          bus.REQ_VALID[1]   = 1'($urandom_range(0, 1));
          bus.REQ_DATA[15:8] = 8'($urandom);
          @(negedge clk);
          if (bus.REQ_READY[1]) bad++;
        end
        bus.REQ_VALID[1] = 1'b0;
      end
    join
    n_checks++;
    if (bad != 0) $display("FAIL nongrant_ready: got %0d cycles with READY[1]=1, expected 0", bad);
    else n_pass++;
    wait_idle("nongrant");
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    int w0;
    sb.push_back(8'hA0); sb.push_back(8'h31);
    send_byte(0, 8'h31, 1'b0);
    bus.REQ_VALID[0]  = 1'b1;
    bus.REQ_DATA[7:0] = 8'h32;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.TX_WR, bus.TX_WDATA, bus.BUSY, bus.ABORT, bus.REQ_READY, bus.GRANT} !== '0)
      $display("FAIL reset_mid_outputs: got wr=%b wdata=%02h busy=%b abort=%b ready=%b grant=%b, expected all 0",
               bus.TX_WR, bus.TX_WDATA, bus.BUSY, bus.ABORT, bus.REQ_READY, bus.GRANT);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL reset_mid_sent: got %0d bytes pending, expected 0", sb.size());
    else n_pass++;
    repeat (3) @(negedge clk);
    bus.REQ_VALID[0] = 1'b0;
    rst = 1'b0;
    w0 = wr_cnt;
    repeat (100) @(negedge clk);
    n_checks++;
    if (wr_cnt != w0) $display("FAIL reset_mid_quiet: got %0d writes, expected 0", wr_cnt - w0);
    else n_pass++;
    q = '{8'h5A};
    push_pkt(2, q);
    send_pkt(2, q);
    wait_idle("post_reset");
  endtask

  task automatic test_force_idle();
    logic [7:0] q[$];
    int w0;
    force_idle = 1'b1;
    min_gap    = 3;
    w0 = wr_cnt;
    q = '{8'hFF};
    push_pkt(0, q);
    send_pkt(0, q);
    wait_idle("force");
    n_checks++;
    if (wr_cnt - w0 != 3) $display("FAIL force_wr_count: got %0d, expected 3", wr_cnt - w0);
    else n_pass++;
    force_idle = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    min_gap = FRAME;
  endtask

  initial begin
    test_reset();
    test_rr();
    test_single();
    test_stall();
    test_nongrant();
    test_reset_mid();
    test_force_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
